u_rf: RTL and testbench

Integer register file with write-back receiver and pending-write scoreboard for the RV32I core. It accepts the delayed write-back stream produced by `u_exe`'s three-stage write buffer on its single write port. It serves two combinational read ports to decode/`u_exe`. It tracks in-flight destination registers so the issue logic can stall on RAW hazards that the write buffer latency would otherwise expose.

---
 rtl/rv_pkg.sv | 16 +
 rtl/u_rf_if.sv | 43 ++++
 rtl/u_rf_sb.sv | 94 +++++++++
 rtl/u_rf.sv | 69 ++++++
 tb/tb_u_rf.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared RV32I core constants and register-address type.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/u_rf_if.sv
`default_nettype none
// ============================================================================
// Module   : u_rf_if
// Brief    : Read, write-back, issue and hazard-status bundle of the integer
//            register file.
// Revision : 1.0 - initial release
// ============================================================================
interface u_rf_if;
  import rv_pkg::*;

  // Read ports
  reg_addr_t         rs1_a;
  reg_addr_t         rs2_a;
  logic [XLEN-1:0]   rf_rs1_o;
  logic [XLEN-1:0]   rf_rs2_o;
  // Write-back port
  logic              rf_rd_e;
  reg_addr_t         rf_rd_a;
  logic [XLEN-1:0]   rf_rd_i;
  // Issue tracking
  logic              iss_v;
  reg_addr_t         iss_rd_a;
  // Hazard status
  logic              rs1_busy;
  logic              rs2_busy;
  logic              stall;
  logic              pend_ovf;
  logic              pend_unf;

  // Core side: drives addresses, write-back and issue
  modport master (
    output rs1_a, rs2_a, rf_rd_e, rf_rd_a, rf_rd_i, iss_v, iss_rd_a,
    input  rf_rs1_o, rf_rs2_o, rs1_busy, rs2_busy, stall, pend_ovf, pend_unf
  );

  // Register-file side
  modport slave (
    input  rs1_a, rs2_a, rf_rd_e, rf_rd_a, rf_rd_i, iss_v, iss_rd_a,
    output rf_rs1_o, rf_rs2_o, rs1_busy, rs2_busy, stall, pend_ovf, pend_unf
  );

endinterface : u_rf_if
`default_nettype wire

// File: rtl/u_rf_sb.sv
`default_nettype none
// ============================================================================
// Module   : u_rf_sb
// Brief    : Pending-write scoreboard: one saturating counter per x1..x31,
//            read-port busy generation and sticky over/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module u_rf_sb
  import rv_pkg::*;
#(
  parameter int PEND_W = 3
) (
  input  wire logic      clk,
  input  wire logic      rstn,
  input  wire reg_addr_t i_rs1_a,
  input  wire reg_addr_t i_rs2_a,
  input  wire logic      i_iss_v,
  input  wire reg_addr_t i_iss_rd_a,
  input  wire logic      i_ret_v,
  input  wire reg_addr_t i_ret_a,
  output logic           o_rs1_busy,
  output logic           o_rs2_busy,
  output logic           o_pend_ovf,
  output logic           o_pend_unf
);

  localparam logic [PEND_W-1:0] C_CNT_MAX = '1;
  localparam logic [PEND_W-1:0] C_CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]   w_ovf_hit;
  logic [NREG-1:0]   w_unf_hit;
  logic              r_pend_ovf;
  logic              r_pend_unf;
  logic              w_rs1_ret;
  logic              w_rs2_ret;

  // x0 is never tracked
  assign w_cnt[0]     = '0;
  assign w_ovf_hit[0] = 1'b0;
  assign w_unf_hit[0] = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
    logic [PEND_W-1:0] r_cnt;
    logic              w_iss;
    logic              w_ret;

    assign w_iss = i_iss_v && (i_iss_rd_a == reg_addr_t'(gi));
    assign w_ret = i_ret_v && (i_ret_a == reg_addr_t'(gi));
    // Same-register issue+retire cancels, so neither flag can fire then
    assign w_ovf_hit[gi] = w_iss && !w_ret && (r_cnt == C_CNT_MAX);
    assign w_unf_hit[gi] = w_ret && !w_iss && (r_cnt == '0);

    // Pending counter: saturates at max on issue, holds at 0 on retire
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_cnt <= '0;
      end else if (w_iss && !w_ret && !w_ovf_hit[gi]) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end else if (w_ret && !w_iss && !w_unf_hit[gi]) begin
        r_cnt <= r_cnt - C_CNT_ONE;
      end
    end

    assign w_cnt[gi] = r_cnt;
  end : g_cnt

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_ovf <= 1'b0;
      r_pend_unf <= 1'b0;
    end else begin
      r_pend_ovf <= r_pend_ovf | (|w_ovf_hit);
      r_pend_unf <= r_pend_unf | (|w_unf_hit);
    end
  end

  // A retire of the last pending write this cycle is served by the bypass
  assign w_rs1_ret = i_ret_v && (i_ret_a == i_rs1_a);
  assign w_rs2_ret = i_ret_v && (i_ret_a == i_rs2_a);

  assign o_rs1_busy = (i_rs1_a != '0) &&
                      ((w_cnt[i_rs1_a] > C_CNT_ONE) ||
                       ((w_cnt[i_rs1_a] == C_CNT_ONE) && !w_rs1_ret));
  assign o_rs2_busy = (i_rs2_a != '0) &&
                      ((w_cnt[i_rs2_a] > C_CNT_ONE) ||
                       ((w_cnt[i_rs2_a] == C_CNT_ONE) && !w_rs2_ret));

  assign o_pend_ovf = r_pend_ovf;
  assign o_pend_unf = r_pend_unf;

endmodule : u_rf_sb
`default_nettype wire

// File: rtl/u_rf.sv
`default_nettype none
// ============================================================================
// Module   : u_rf
// Brief    : RV32I integer register file: x1..x31 storage, write-through
//            bypass on both read ports, and pending-write hazard tracking.
// Revision : 1.0 - initial release
// ============================================================================
module u_rf
  import rv_pkg::*;
#(
  parameter int PEND_W = 3
) (
  input  wire logic clk,
  input  wire logic rstn,
  u_rf_if.slave     rf_bus
);

  logic [XLEN-1:0] w_regs [NREG];
  logic            w_rs1_byp;
  logic            w_rs2_byp;

  // x0 has no storage
  assign w_regs[0] = '0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
    logic [XLEN-1:0] r_q;

    // Capture write-back data addressed to this register
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_q <= '0;
      end else if (rf_bus.rf_rd_e && (rf_bus.rf_rd_a == reg_addr_t'(gi))) begin
        r_q <= rf_bus.rf_rd_i;
      end
    end

    assign w_regs[gi] = r_q;
  end : g_reg

  // Same-cycle write-back is forwarded so readers never see stale data
  assign w_rs1_byp = rf_bus.rf_rd_e && (rf_bus.rf_rd_a == rf_bus.rs1_a);
  assign w_rs2_byp = rf_bus.rf_rd_e && (rf_bus.rf_rd_a == rf_bus.rs2_a);

  assign rf_bus.rf_rs1_o = (rf_bus.rs1_a == '0) ? '0 :
                           w_rs1_byp ? rf_bus.rf_rd_i : w_regs[rf_bus.rs1_a];
  assign rf_bus.rf_rs2_o = (rf_bus.rs2_a == '0) ? '0 :
                           w_rs2_byp ? rf_bus.rf_rd_i : w_regs[rf_bus.rs2_a];

  u_rf_sb #(
    .PEND_W (PEND_W)
  ) u_sb (
    .clk        (clk),
    .rstn       (rstn),
    .i_rs1_a    (rf_bus.rs1_a),
    .i_rs2_a    (rf_bus.rs2_a),
    .i_iss_v    (rf_bus.iss_v),
    .i_iss_rd_a (rf_bus.iss_rd_a),
    .i_ret_v    (rf_bus.rf_rd_e),
    .i_ret_a    (rf_bus.rf_rd_a),
    .o_rs1_busy (rf_bus.rs1_busy),
    .o_rs2_busy (rf_bus.rs2_busy),
    .o_pend_ovf (rf_bus.pend_ovf),
    .o_pend_unf (rf_bus.pend_unf)
  );

  assign rf_bus.stall = rf_bus.rs1_busy | rf_bus.rs2_busy;

endmodule : u_rf
`default_nettype wire

// File: tb/tb_u_rf.sv
`default_nettype none
// ============================================================================
// Module   : tb_u_rf
// Brief    : Scoreboard bench for u_rf: stimulus pushes expected outputs from
//            an array/counter reference model, a negedge monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_u_rf;
  import rv_pkg::*;

  localparam int PEND_W  = 3;
  localparam int CNT_MAX = (1 << PEND_W) - 1;

  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  u_rf_if bus ();

  u_rf #(
    .PEND_W (PEND_W)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rf_bus (bus)
  );

  typedef struct {
    int          tag;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        b1;
    logic        b2;
    logic        st;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        q[$];
  int          m_cnt [32];
  logic [31:0] m_mem [32];
  logic        m_ovf;
  logic        m_unf;
  int          checks = 0;
  int          errors = 0;
  int          tag    = 0;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_mem[i] = 32'h0;
    end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  // Reference read: x0 is zero, otherwise newest value including this cycle's write
  function automatic logic [31:0] m_read(int a);
    if (a == 0) return 32'h0;
    if (bus.rf_rd_e && int'(bus.rf_rd_a) == a) return bus.rf_rd_i;
    return m_mem[a];
  endfunction

  // Busy when outstanding writes remain after any write-back arriving now
  function automatic logic m_busy(int a);
    int ret;
    ret = (bus.rf_rd_e && int'(bus.rf_rd_a) == a) ? 1 : 0;
    return (a != 0) && ((m_cnt[a] - ret) > 0);
  endfunction

  function automatic void push_exp(int r1, int r2);
    exp_t e;
    tag++;
    e.tag = tag;
    e.rs1 = m_read(r1);
    e.rs2 = m_read(r2);
    e.b1  = m_busy(r1);
    e.b2  = m_busy(r2);
    e.st  = e.b1 | e.b2;
    e.ovf = m_ovf;
    e.unf = m_unf;
    q.push_back(e);
  endfunction

  task automatic step(input logic iv, input int ia, input logic we, input int wa,
                      input logic [31:0] wd, input int r1, input int r2);
    @(posedge clk);
    #1;
    bus.iss_v    = iv;
    bus.iss_rd_a = reg_addr_t'(ia);
    bus.rf_rd_e  = we;
    bus.rf_rd_a  = reg_addr_t'(wa);
    bus.rf_rd_i  = wd;
    bus.rs1_a    = reg_addr_t'(r1);
    bus.rs2_a    = reg_addr_t'(r2);
    push_exp(r1, r2);
    // State change at the coming edge
    if (!(iv && ia != 0 && we && wa == ia)) begin
      if (iv && ia != 0) begin
        if (m_cnt[ia] == CNT_MAX) m_ovf = 1'b1;
        else m_cnt[ia] = m_cnt[ia] + 1;
      end
      if (we && wa != 0) begin
        if (m_cnt[wa] == 0) m_unf = 1'b1;
        else m_cnt[wa] = m_cnt[wa] - 1;
      end
    end
    if (we && wa != 0) m_mem[wa] = wd;
  endtask

  task automatic idle(input int r1, input int r2);
    step(1'b0, 0, 1'b0, 0, 32'h0, r1, r2);
  endtask

  // Assert reset between edges and expect everything cleared before the next edge
  task automatic mid_reset(input int r1, input int r2);
    @(posedge clk);
    #1;
    bus.iss_v   = 1'b0;
    bus.rf_rd_e = 1'b0;
    bus.rs1_a   = reg_addr_t'(r1);
    bus.rs2_a   = reg_addr_t'(r2);
    rstn        = 1'b0;
    model_reset();
    push_exp(r1, r2);
    @(posedge clk);
    #1;
    push_exp(r1, r2);
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic chk(input string n, input int t, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tag=%0d actual=%h expected=%h", n, t, act, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs1_data", e.tag, bus.rf_rs1_o, e.rs1);
      chk("rs2_data", e.tag, bus.rf_rs2_o, e.rs2);
      chk("rs1_busy", e.tag, 32'(bus.rs1_busy), 32'(e.b1));
      chk("rs2_busy", e.tag, 32'(bus.rs2_busy), 32'(e.b2));
      chk("stall",    e.tag, 32'(bus.stall),    32'(e.st));
      chk("pend_ovf", e.tag, 32'(bus.pend_ovf), 32'(e.ovf));
      chk("pend_unf", e.tag, 32'(bus.pend_unf), 32'(e.unf));
    end
  end

  initial begin
    bus.iss_v    = 1'b0;
    bus.iss_rd_a = '0;
    bus.rf_rd_e  = 1'b0;
    bus.rf_rd_a  = '0;
    bus.rf_rd_i  = '0;
    bus.rs1_a    = '0;
    bus.rs2_a    = '0;
    model_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rstn = 1'b1;

    // Every address reads zero after reset
    for (int k = 0; k < 16; k++) idle(2 * k, 2 * k + 1);

    // Write-through then storage
    step(1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 5, 0);
    idle(5, 0);

    // x0 writes and issues are ignored
    step(1'b0, 0, 1'b1, 0, 32'h12345678, 0, 0);
    idle(5, 0);
    step(1'b1, 0, 1'b0, 0, 32'h0, 0, 0);
    idle(0, 0);

    // Single in-flight write to x7
    step(1'b1, 7, 1'b0, 0, 32'h0, 7, 0);
    repeat (3) idle(7, 0);
    step(1'b0, 0, 1'b1, 7, 32'h000000A5, 7, 0);
    idle(7, 0);

    // Multiple in-flight writes to x3, then same-cycle issue+retire
    repeat (3) step(1'b1, 3, 1'b0, 0, 32'h0, 0, 3);
    step(1'b0, 0, 1'b1, 3, 32'h33, 0, 3);
    step(1'b1, 3, 1'b1, 3, 32'h34, 0, 3);
    idle(3, 3);

    // Saturation of x9 and underflow on x10
    repeat (8) step(1'b1, 9, 1'b0, 0, 32'h0, 9, 0);
    idle(9, 0);
    step(1'b0, 0, 1'b1, 10, 32'h00000055, 10, 9);
    idle(10, 9);

    // Randomized traffic on a small register window to force collisions
    for (int k = 0; k < 400; k++) begin
      logic iv, we;
      int ia, wa, r1, r2;
      iv = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ia = int'($urandom_range(0, 7));
      wa = int'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      r2 = int'($urandom_range(0, 7));
      step(iv, ia, we, wa, $urandom, r1, r2);
    end

    // Asynchronous reset with x4 pending
    step(1'b1, 4, 1'b0, 0, 32'h0, 4, 5);
    idle(4, 5);
    mid_reset(4, 5);
    idle(4, 9);
    for (int k = 0; k < 50; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
    idle(0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_u_rf
`default_nettype wire
